// File: rtl/operand_issue_ctrl.sv
// operand_issue_ctrl
// Issue-stage controller sitting between decode and execute. Tracks
// in-flight destination registers in a scoreboard, stalls decode on
// RAW/WAW hazards, sequences multi-cycle ALU operations and drives the
// registered execute-stage control fields plus the operand-B select.
module operand_issue_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int OP_W       = 4,
    parameter int MULTI_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [OP_W-1:0]       dec_op,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_use_imm,
    input  logic                  dec_wr_en,
    input  logic                  dec_multi,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  ex_valid,
    output logic [OP_W-1:0]       ex_op,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_wr_en,
    output logic                  sel_operB,
    output logic                  ex_busy
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    // Counter only needs to hold MULTI_LAT-1; keep at least one bit.
    localparam int CNT_W = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(MULTI_LAT - 1);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    // One-hot decode of a register index into a scoreboard-wide mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] v;
        v = {NUM_REGS{1'b0}};
        v[addr] = 1'b1;
        return v;
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [NUM_REGS-1:0]   pend_r;
    logic [NUM_REGS-1:0]   pend_eff_s;
    logic [NUM_REGS-1:0]   pend_nxt_s;
    logic [NUM_REGS-1:0]   wb_mask_s;
    logic                  hazard_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  ex_valid_r;
    logic [OP_W-1:0]       ex_op_r;
    logic [REG_ADDR_W-1:0] ex_rd_r;
    logic                  ex_wr_en_r;
    logic                  sel_operb_r;
    logic                  ex_busy_r;

    // Same-cycle writeback bypass: a completing register no longer counts as pending.
    always_comb begin
        wb_mask_s = {NUM_REGS{1'b0}};
        if (wb_valid) begin
            wb_mask_s = reg_onehot(wb_rd);
        end else begin
            wb_mask_s = {NUM_REGS{1'b0}};
        end
        pend_eff_s = pend_r & ~wb_mask_s;
    end

    // RAW on either used source, or WAW on the destination when it is written.
    always_comb begin
        hazard_s = pend_eff_s[dec_rs1]
                 | (~dec_use_imm & pend_eff_s[dec_rs2])
                 | (dec_wr_en & pend_eff_s[dec_rd]);
    end

    // FSM output logic: readiness is held low while in reset so decode never fires into it.
    always_comb begin
        ready_s  = 1'b0;
        accept_s = 1'b0;
        if (rst_n && (state_r == ST_IDLE) && !hazard_s) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = dec_valid & ready_s;
    end

    // FSM next-state logic; the counter runs from MULTI_LAT-1 down to 0 so the
    // op stays busy for MULTI_LAT cycles starting at its issue strobe.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && dec_multi) begin
                    state_nxt_s = ST_MULTI;
                    cnt_nxt_s   = LAT_M1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_MULTI: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_MULTI;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Scoreboard update: a new destination set wins over a same-cycle writeback; r0 never pends.
    always_comb begin
        pend_nxt_s = pend_eff_s;
        if (accept_s && dec_wr_en && (dec_rd != REG_ZERO)) begin
            pend_nxt_s = pend_eff_s | reg_onehot(dec_rd);
        end else begin
            pend_nxt_s = pend_eff_s;
        end
        pend_nxt_s[0] = 1'b0;
    end

    // FSM state and multi-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Pending-destination scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= {NUM_REGS{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Issue strobe and busy flag, both registered so execute sees clean levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_busy_r  <= 1'b0;
        end else begin
            ex_valid_r <= accept_s;
            ex_busy_r  <= (state_nxt_s == ST_MULTI);
        end
    end

    // Execute control fields capture on accept and otherwise hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_op_r     <= {OP_W{1'b0}};
            ex_rd_r     <= REG_ZERO;
            ex_wr_en_r  <= 1'b0;
            sel_operb_r <= 1'b0;
        end else if (accept_s) begin
            ex_op_r     <= dec_op;
            ex_rd_r     <= dec_rd;
            ex_wr_en_r  <= dec_wr_en;
            sel_operb_r <= dec_use_imm;
        end else begin
            ex_op_r     <= ex_op_r;
            ex_rd_r     <= ex_rd_r;
            ex_wr_en_r  <= ex_wr_en_r;
            sel_operb_r <= sel_operb_r;
        end
    end

    assign dec_ready = ready_s;
    assign ex_valid  = ex_valid_r;
    assign ex_op     = ex_op_r;
    assign ex_rd     = ex_rd_r;
    assign ex_wr_en  = ex_wr_en_r;
    assign sel_operB = sel_operb_r;
    assign ex_busy   = ex_busy_r;

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Directed self-checking bench for operand_issue_ctrl (default parameters,
// MULTI_LAT=4). Inputs change and outputs are sampled 1ns after the rising edge.
`timescale 1ns/1ps
module tb_operand_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       dec_valid;
    logic       dec_ready;
    logic [3:0] dec_op;
    logic [3:0] dec_rd;
    logic [3:0] dec_rs1;
    logic [3:0] dec_rs2;
    logic       dec_use_imm;
    logic       dec_wr_en;
    logic       dec_multi;
    logic       wb_valid;
    logic [3:0] wb_rd;
    logic       ex_valid;
    logic [3:0] ex_op;
    logic [3:0] ex_rd;
    logic       ex_wr_en;
    logic       sel_operB;
    logic       ex_busy;

    int total = 0;
    int bad   = 0;

    operand_issue_ctrl #(.REG_ADDR_W(4), .OP_W(4), .MULTI_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_imm(dec_use_imm), .dec_wr_en(dec_wr_en), .dec_multi(dec_multi),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
        .sel_operB(sel_operB), .ex_busy(ex_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 1'b0; dec_op = 4'h0; dec_rd = 4'h0; dec_rs1 = 4'h0; dec_rs2 = 4'h0;
        dec_use_imm = 1'b1; dec_wr_en = 1'b0; dec_multi = 1'b0;
        wb_valid = 1'b0; wb_rd = 4'h0;
    endtask

    // Present one instruction (held until caller ticks).
    task automatic present(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic imm, input logic wr, input logic multi);
        dec_valid = 1'b1; dec_op = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_use_imm = imm; dec_wr_en = wr; dec_multi = multi;
    endtask

    task automatic issue_one(input logic [3:0] rd);
        present(4'h1, rd, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        dec_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] r);
        wb_valid = 1'b1; wb_rd = r;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        total++; if (ex_valid !== 1'b0) begin $display("FAIL rst_ex_valid got=%b exp=0", ex_valid); bad++; end
        total++; if (ex_busy !== 1'b0) begin $display("FAIL rst_ex_busy got=%b exp=0", ex_busy); bad++; end
        total++; if (sel_operB !== 1'b0) begin $display("FAIL rst_sel_operB got=%b exp=0", sel_operB); bad++; end
        total++; if ({ex_op, ex_rd, ex_wr_en} !== 9'h000) begin $display("FAIL rst_ex_fields got=%h exp=000", {ex_op, ex_rd, ex_wr_en}); bad++; end
        total++; if (dec_ready !== 1'b0) begin $display("FAIL rst_dec_ready got=%b exp=0", dec_ready); bad++; end
        rst_n = 1'b1;
        #1;
        total++; if (dec_ready !== 1'b1) begin $display("FAIL rst_release_ready got=%b exp=1", dec_ready); bad++; end
    endtask

    task automatic test_independent();
        for (int i = 1; i <= 3; i++) begin
            present(4'(i + 4), 4'(i), 4'h4, 4'h5, 1'b0, 1'b1, 1'b0);
            #1;
            total++; if (dec_ready !== 1'b1) begin $display("FAIL indep_ready%0d got=%b exp=1", i, dec_ready); bad++; end
            tick();
            total++; if (ex_valid !== 1'b1 || ex_rd !== 4'(i) || ex_op !== 4'(i + 4) || sel_operB !== 1'b0)
                begin $display("FAIL indep_issue%0d got v=%b rd=%h op=%h sel=%b exp v=1 rd=%h op=%h sel=0", i, ex_valid, ex_rd, ex_op, sel_operB, i, i + 4); bad++; end
        end
        idle_inputs();
        tick();
        total++; if (ex_valid !== 1'b0) begin $display("FAIL indep_strobe_drop got=%b exp=0", ex_valid); bad++; end
        // Probe scoreboard through the hazard path: 1,2,3 pending, 4 not.
        for (int r = 1; r <= 4; r++) begin
            dec_rs1 = 4'(r);
            #1;
            total++; if (dec_ready !== (r == 4)) begin $display("FAIL indep_pend%0d ready got=%b exp=%b", r, dec_ready, (r == 4)); bad++; end
        end
        dec_rs1 = 4'h0;
        do_wb(4'h1); do_wb(4'h2); do_wb(4'h3);
    endtask

    task automatic test_raw();
        issue_one(4'h5);
        present(4'h2, 4'h6, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if (dec_ready !== 1'b0) begin $display("FAIL raw_stall got=%b exp=0", dec_ready); bad++; end
        tick();
        total++; if (ex_valid !== 1'b0) begin $display("FAIL raw_no_issue got=%b exp=0", ex_valid); bad++; end
        wb_valid = 1'b1; wb_rd = 4'h5;
        #1;
        total++; if (dec_ready !== 1'b1) begin $display("FAIL raw_bypass_ready got=%b exp=1", dec_ready); bad++; end
        tick();
        total++; if (ex_valid !== 1'b1 || ex_rd !== 4'h6) begin $display("FAIL raw_issue got v=%b rd=%h exp v=1 rd=6", ex_valid, ex_rd); bad++; end
        idle_inputs();
        do_wb(4'h6);
    endtask

    task automatic test_imm();
        issue_one(4'h7);
        present(4'hA, 4'h8, 4'h0, 4'h7, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (dec_ready !== 1'b1) begin $display("FAIL imm_ready got=%b exp=1", dec_ready); bad++; end
        tick();
        total++; if (ex_valid !== 1'b1 || sel_operB !== 1'b1 || ex_op !== 4'hA || ex_wr_en !== 1'b0)
            begin $display("FAIL imm_issue got v=%b sel=%b op=%h wr=%b exp v=1 sel=1 op=a wr=0", ex_valid, sel_operB, ex_op, ex_wr_en); bad++; end
        present(4'hB, 4'h8, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (dec_ready !== 1'b0) begin $display("FAIL imm_reg_stall got=%b exp=0", dec_ready); bad++; end
        tick();
        total++; if (ex_valid !== 1'b0 || sel_operB !== 1'b1 || ex_op !== 4'hA)
            begin $display("FAIL imm_hold got v=%b sel=%b op=%h exp v=0 sel=1 op=a", ex_valid, sel_operB, ex_op); bad++; end
        idle_inputs();
        do_wb(4'h7);
    endtask

    task automatic test_multi();
        present(4'h3, 4'h9, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        tick();
        total++; if (ex_valid !== 1'b1 || ex_busy !== 1'b1 || sel_operB !== 1'b1 || dec_ready !== 1'b0)
            begin $display("FAIL multi_c1 got v=%b busy=%b sel=%b rdy=%b exp 1 1 1 0", ex_valid, ex_busy, sel_operB, dec_ready); bad++; end
        // Hazard-free single op waiting at decode; must not be taken while busy.
        present(4'h4, 4'hA, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            total++; if (ex_valid !== 1'b0 || ex_busy !== 1'b1 || sel_operB !== 1'b1 || dec_ready !== 1'b0 || ex_op !== 4'h3)
                begin $display("FAIL multi_c%0d got v=%b busy=%b sel=%b rdy=%b op=%h exp 0 1 1 0 3", c, ex_valid, ex_busy, sel_operB, dec_ready, ex_op); bad++; end
        end
        tick();
        total++; if (ex_busy !== 1'b0 || dec_ready !== 1'b1 || ex_valid !== 1'b0)
            begin $display("FAIL multi_exit got busy=%b rdy=%b v=%b exp 0 1 0", ex_busy, dec_ready, ex_valid); bad++; end
        tick();
        total++; if (ex_valid !== 1'b1 || ex_rd !== 4'hA || sel_operB !== 1'b0)
            begin $display("FAIL multi_next_issue got v=%b rd=%h sel=%b exp 1 a 0", ex_valid, ex_rd, sel_operB); bad++; end
        idle_inputs();
        do_wb(4'h9); do_wb(4'hA);
    endtask

    task automatic test_waw();
        issue_one(4'h3);
        present(4'h5, 4'h3, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        wb_valid = 1'b1; wb_rd = 4'h3;
        #1;
        total++; if (dec_ready !== 1'b1) begin $display("FAIL waw_ready got=%b exp=1", dec_ready); bad++; end
        tick();
        total++; if (ex_valid !== 1'b1 || ex_rd !== 4'h3) begin $display("FAIL waw_issue got v=%b rd=%h exp 1 3", ex_valid, ex_rd); bad++; end
        idle_inputs();
        dec_rs1 = 4'h3;
        #1;
        total++; if (dec_ready !== 1'b0) begin $display("FAIL waw_set_wins got=%b exp=0", dec_ready); bad++; end
        idle_inputs();
        do_wb(4'h3);
        issue_one(4'h0);
        dec_rd = 4'h0; dec_wr_en = 1'b1; dec_rs1 = 4'h0;
        #1;
        total++; if (dec_ready !== 1'b1) begin $display("FAIL r0_never_pend got=%b exp=1", dec_ready); bad++; end
        // Writeback to a non-pending register must not disturb anything.
        idle_inputs();
        do_wb(4'hC);
        dec_rs1 = 4'hC;
        #1;
        total++; if (dec_ready !== 1'b1) begin $display("FAIL wb_nonpend got=%b exp=1", dec_ready); bad++; end
        idle_inputs();
    endtask

    task automatic test_reset_multi();
        present(4'h6, 4'hB, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        tick();
        idle_inputs();
        tick();
        total++; if (ex_busy !== 1'b1) begin $display("FAIL rm_busy_before got=%b exp=1", ex_busy); bad++; end
        rst_n = 1'b0;
        #1;
        total++; if (ex_busy !== 1'b0 || ex_valid !== 1'b0 || sel_operB !== 1'b0 || dec_ready !== 1'b0)
            begin $display("FAIL rm_async got busy=%b v=%b sel=%b rdy=%b exp 0 0 0 0", ex_busy, ex_valid, sel_operB, dec_ready); bad++; end
        tick();
        rst_n = 1'b1;
        dec_rs1 = 4'hB; dec_rd = 4'hB; dec_wr_en = 1'b1;
        #1;
        total++; if (dec_ready !== 1'b1) begin $display("FAIL rm_sb_clear got=%b exp=1", dec_ready); bad++; end
        tick();
        total++; if (ex_busy !== 1'b0) begin $display("FAIL rm_stays_idle got=%b exp=0", ex_busy); bad++; end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_imm();
        test_multi();
        test_waw();
        test_reset_multi();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
